// File: rtl/cr16_muldiv.sv
// cr16_muldiv: iterative multiply/divide unit for the CR16 execute stage.
// Shift-add multiply and restoring divide run on operand magnitudes, one bit
// per cycle. The sign fix-up is applied on the last iteration edge.
// Divide-by-zero and signed overflow bypass the iteration and finish on the
// accept edge.
module cr16_muldiv #(
  parameter int P_WIDTH = 16
) (
  input  logic               I_CLK,
  input  logic               I_NRESET,
  input  logic               I_FLUSH,
  input  logic               I_VALID,
  output logic               O_READY,
  input  logic [2:0]         I_OPCODE,
  input  logic [P_WIDTH-1:0] I_A,
  input  logic [P_WIDTH-1:0] I_B,
  output logic               O_VALID,
  input  logic               I_READY,
  output logic [P_WIDTH-1:0] O_C,
  output logic [4:0]         O_STATUS
);

  localparam int                 CW       = $clog2(P_WIDTH + 1);
  localparam logic [CW-1:0]      CNT_LOAD = CW'(P_WIDTH);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
  localparam logic [P_WIDTH-1:0] ALL_ONES = {P_WIDTH{1'b1}};
  localparam logic [P_WIDTH-1:0] ZERO_W   = {P_WIDTH{1'b0}};
  localparam logic [P_WIDTH-1:0] MOST_NEG = {1'b1, {(P_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Packs the ALU-compatible status word: {NEGATIVE, ZERO, FLAG, LOW, CARRY}.
  function automatic logic [4:0] status_f(input logic [P_WIDTH-1:0] res,
                                          input logic is_signed,
                                          input logic carry,
                                          input logic flag);
    status_f = {is_signed & res[P_WIDTH-1], (res == ZERO_W), flag, 1'b0, carry};
  endfunction

  // Magnitude of an operand; unsigned operands pass through unchanged.
  function automatic logic [P_WIDTH-1:0] abs_f(input logic [P_WIDTH-1:0] v,
                                               input logic is_signed);
    if (is_signed && v[P_WIDTH-1]) begin
      abs_f = ZERO_W - v;
    end else begin
      abs_f = v;
    end
  endfunction

  state_t               state_r, state_nx_s;
  logic [2:0]           op_r;
  logic [P_WIDTH-1:0]   opb_r;        // multiplicand or divisor magnitude
  logic [P_WIDTH-1:0]   hi_r;         // product high half or partial remainder
  logic [P_WIDTH-1:0]   lo_r;         // multiplier / dividend, shifting out
  logic                 neg_q_r;      // product / quotient must be negated
  logic                 neg_r_r;      // remainder must be negated
  logic [CW-1:0]        cnt_r;
  logic [P_WIDTH-1:0]   c_r;
  logic [4:0]           status_r;
  logic                 valid_r;

  logic                 in_div_s, in_signed_s, div0_s, ovf_s, special_s;
  logic [P_WIDTH-1:0]   a_mag_s, b_mag_s, special_res_s;
  logic [P_WIDTH:0]     mul_sum_s, div_pr_s, div_diff_s;
  logic                 div_ge_s;
  logic [P_WIDTH-1:0]   hi_nx_s, lo_nx_s;
  logic [2*P_WIDTH-1:0] prod_mag_s, prod_s;
  logic [P_WIDTH-1:0]   quo_s, rem_s, fin_res_s;
  logic                 fin_carry_s;
  logic [4:0]           fin_status_s;

  // Decode the incoming request and detect the fixed-result cases.
  always_comb begin
    in_div_s    = I_OPCODE[2];
    in_signed_s = ~I_OPCODE[0];
    a_mag_s     = abs_f(I_A, in_signed_s);
    b_mag_s     = abs_f(I_B, in_signed_s);
    div0_s      = in_div_s & (I_B == ZERO_W);
    ovf_s       = in_div_s & in_signed_s & (I_A == MOST_NEG) & (I_B == ALL_ONES);
    special_s   = div0_s | ovf_s;
    if (div0_s) begin
      special_res_s = I_OPCODE[1] ? I_A : ALL_ONES;
    end else if (ovf_s) begin
      special_res_s = I_OPCODE[1] ? ZERO_W : MOST_NEG;
    end else begin
      special_res_s = ZERO_W;
    end
  end

  // One shift-add or restoring-divide step on the held magnitudes.
  always_comb begin
    mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(P_WIDTH+1){1'b0}});
    div_pr_s   = {hi_r, lo_r[P_WIDTH-1]};
    div_ge_s   = (div_pr_s >= {1'b0, opb_r});
    div_diff_s = div_pr_s - {1'b0, opb_r};
    if (op_r[2]) begin
      hi_nx_s = div_ge_s ? div_diff_s[P_WIDTH-1:0] : div_pr_s[P_WIDTH-1:0];
      lo_nx_s = {lo_r[P_WIDTH-2:0], div_ge_s};
    end else begin
      hi_nx_s = mul_sum_s[P_WIDTH:1];
      lo_nx_s = {mul_sum_s[0], lo_r[P_WIDTH-1:1]};
    end
  end

  // Sign fix-up and result selection from the final iteration values.
  always_comb begin
    prod_mag_s  = {hi_nx_s, lo_nx_s};
    prod_s      = neg_q_r ? ({(2*P_WIDTH){1'b0}} - prod_mag_s) : prod_mag_s;
    quo_s       = neg_q_r ? (ZERO_W - lo_nx_s) : lo_nx_s;
    rem_s       = neg_r_r ? (ZERO_W - hi_nx_s) : hi_nx_s;
    fin_carry_s = 1'b0;
    case (op_r)
      3'd0: begin
        fin_res_s   = prod_s[P_WIDTH-1:0];
        fin_carry_s = ~((&prod_s[2*P_WIDTH-1:P_WIDTH-1]) | ~(|prod_s[2*P_WIDTH-1:P_WIDTH-1]));
      end
      3'd1: begin
        fin_res_s   = prod_s[P_WIDTH-1:0];
        fin_carry_s = |prod_mag_s[2*P_WIDTH-1:P_WIDTH];
      end
      3'd2, 3'd3: fin_res_s = prod_s[2*P_WIDTH-1:P_WIDTH];
      3'd4, 3'd5: fin_res_s = quo_s;
      3'd6, 3'd7: fin_res_s = rem_s;
      default:    fin_res_s = ZERO_W;
    endcase
    fin_status_s = status_f(fin_res_s, ~op_r[0], fin_carry_s, 1'b0);
  end

  // State register.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; a flush overrides every other transition.
  always_comb begin
    state_nx_s = state_r;
    if (I_FLUSH) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (I_VALID) begin
            state_nx_s = special_s ? ST_DONE : ST_CALC;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (cnt_r == CNT_ONE) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_CALC;
          end
        end
        ST_DONE: begin
          if (I_READY) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DONE;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Output decode: requests are accepted only while idle.
  always_comb begin
    O_READY  = (state_r == ST_IDLE);
    O_VALID  = valid_r;
    O_C      = c_r;
    O_STATUS = status_r;
  end

  // Datapath: latch operands, iterate, and register the result.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      op_r     <= 3'd0;
      opb_r    <= ZERO_W;
      hi_r     <= ZERO_W;
      lo_r     <= ZERO_W;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      cnt_r    <= CNT_ZERO;
      c_r      <= ZERO_W;
      status_r <= 5'd0;
      valid_r  <= 1'b0;
    end else if (I_FLUSH) begin
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (I_VALID) begin
            op_r    <= I_OPCODE;
            opb_r   <= in_div_s ? b_mag_s : a_mag_s;
            lo_r    <= in_div_s ? a_mag_s : b_mag_s;
            hi_r    <= ZERO_W;
            neg_q_r <= in_signed_s & (I_A[P_WIDTH-1] ^ I_B[P_WIDTH-1]);
            neg_r_r <= in_signed_s & I_A[P_WIDTH-1];
            cnt_r   <= CNT_LOAD;
            if (special_s) begin
              c_r      <= special_res_s;
              status_r <= status_f(special_res_s, in_signed_s, 1'b0, 1'b1);
              valid_r  <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          hi_r  <= hi_nx_s;
          lo_r  <= lo_nx_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            c_r      <= fin_res_s;
            status_r <= fin_status_s;
            valid_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (I_READY) begin
            valid_r <= 1'b0;
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

endmodule
